// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe -- registered ALU with valid/ready handshakes on both sides.
//
// Purpose
//   This block accepts one operation per cycle from issue and returns the
//   result, the status flags and an opaque tag to writeback. Writeback
//   back-pressure (out_ready low) holds the current result stable and stalls
//   issue. Non-MUL operations produce their result one edge after accept.
//
// Optional feature (macro ALU_MUL_EN)
//   When ALU_MUL_EN is defined, opcode 0111 is an unsigned shift-add
//   multiplier. It adds one partial product per cycle, so the FSM stays in
//   BUSY for WIDTH cycles. When ALU_MUL_EN is undefined, there is no
//   multiplier and no BUSY state, and 0111 behaves as an undefined opcode.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   request handshake (ready is low while rst or BUSY)
//   opcode, A, B        operation select and operands
//   in_tag              tag returned unchanged with the result
//   out_valid/out_ready result handshake (valid == state DONE)
//   result, flags       result and {V,C,N,Z}
//   out_tag             tag of the returned operation
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);
`endif

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    // Single-cycle evaluation; returns {V,C,N,Z, result}.
    // Shifts run in a double-width vector so the last bit shifted out lands
    // at a fixed position (bit WIDTH for SHL, bit WIDTH-1 for SHR/SRA). It is
    // zero automatically when the shift amount is zero.
    function automatic logic [WIDTH+3:0] alu_eval(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0]       sum;
        logic [2*WIDTH-1:0]   ext;
        logic [WIDTH-1:0]     res;
        logic                 c;
        logic                 v;
        logic [SHW-1:0]       sh;
        sum = '0;
        ext = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        sh  = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The borrow appears as the extra top bit of the extended difference.
                sum = {1'b0, a} - {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                ext = {{WIDTH{1'b0}}, a} << sh;
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
            end
            OP_SHR: begin
                ext = {a, {WIDTH{1'b0}}} >> sh;
                res = ext[2*WIDTH-1:WIDTH];
                c   = ext[WIDTH-1];
            end
            OP_SRA: begin
                ext = $signed({a, {WIDTH{1'b0}}}) >>> sh;
                res = ext[2*WIDTH-1:WIDTH];
                c   = ext[WIDTH-1];
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res = '0;
        endcase
        return {v, c, res[WIDTH-1], (res == {WIDTH{1'b0}}), res};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               accept_s;
    logic [WIDTH+3:0]   eval_s;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_step_s;
    logic               is_mul_s;

    assign is_mul_s   = (opcode == OP_MUL);
    assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
`endif

    assign accept_s = in_valid & in_ready;
    assign eval_s   = alu_eval(opcode, A, B);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
`ifdef ALU_MUL_EN
                    state_d = is_mul_s ? S_BUSY : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            S_BUSY: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
`endif
            S_DONE: begin
                if (!out_ready) begin
                    state_d = S_DONE;
                end else if (accept_s) begin
`ifdef ALU_MUL_EN
                    state_d = is_mul_s ? S_BUSY : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake signals derived from the registered state
    always_comb begin
        out_valid = (state_q == S_DONE);
        in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    end

    // Datapath next values: capture on accept, iterate while multiplying, else hold
    always_comb begin
        result_d  = result_q;
        flags_d   = flags_q;
        out_tag_d = out_tag_q;
`ifdef ALU_MUL_EN
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
`endif
        if (accept_s) begin
            out_tag_d = in_tag;
`ifdef ALU_MUL_EN
            if (is_mul_s) begin
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, A};
                mplier_d = B;
                cnt_d    = '0;
            end else begin
                {flags_d, result_d} = eval_s;
            end
`else
            {flags_d, result_d} = eval_s;
`endif
        end
`ifdef ALU_MUL_EN
        else if (state_q == S_BUSY) begin
            acc_d    = acc_step_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            // The final partial product is folded straight into the result.
            if (cnt_q == LAST_ITER) begin
                result_d = acc_step_s[WIDTH-1:0];
                flags_d  = {1'b0,
                            (acc_step_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}),
                            acc_step_s[WIDTH-1],
                            (acc_step_s[WIDTH-1:0] == {WIDTH{1'b0}})};
            end else begin
                result_d = result_q;
                flags_d  = flags_q;
            end
        end
`endif
        else begin
            result_d  = result_q;
            flags_d   = flags_q;
            out_tag_d = out_tag_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            flags_q   <= 4'b0000;
            out_tag_q <= '0;
`ifdef ALU_MUL_EN
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            result_q  <= result_d;
            flags_q   <= flags_d;
            out_tag_q <= out_tag_d;
`ifdef ALU_MUL_EN
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign result  = result_q;
    assign flags   = flags_q;
    assign out_tag = out_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// ============================================================================
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH=16, TAG_W=4).
// A transaction-level model holds accepted operations with the cycle at
// which each must become visible. Expected results come from integer
// arithmetic on signed/unsigned interpretations of the operands.
// ============================================================================
module tb_alu_pipe;
    localparam int W  = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [W-1:0]  A, B;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .A(A), .B(B), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .out_tag(out_tag)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [3:0]    flg;
        logic [TW-1:0] tag;
        int            rdy;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    bit   chk_en   = 1'b0;
    bit   rst_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, req, cyc);
        end
    endtask

    function automatic bit op_is_mul(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return (op == 4'd7);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: returns {V,C,N,Z, result}.
    function automatic logic [19:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int ua, ub, sa, sb, r, sh, sres;
        longint p;
        bit c, v;
        logic [15:0] rr;
        ua = int'(a);
        ub = int'(b);
        sa = a[15] ? ua - 65536 : ua;
        sb = b[15] ? ub - 65536 : ub;
        sh = ub % 16;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            4'd0: begin
                r = ua + ub; c = (r > 65535);
                sres = sa + sb; v = (sres > 32767) || (sres < -32768);
            end
            4'd1: begin
                r = ua - ub; c = (ua < ub);
                sres = sa - sb; v = (sres > 32767) || (sres < -32768);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: begin r = ua << sh; c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1); end
            4'd6: begin r = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
            4'd8: begin r = sa >>> sh; c = (sh != 0) && (((sa >>> (sh - 1)) & 1) == 1); end
            4'd9: r = (sa < sb) ? 1 : 0;
            4'd7: begin
                if (op_is_mul(op)) begin
                    p = longint'(ua) * longint'(ub);
                    r = int'(p % 65536);
                    c = ((p / 65536) != 0);
                end else begin
                    r = 0;
                end
            end
            default: r = 0;
        endcase
        rr = r[15:0];
        return {v, c, rr[15], (rr == 16'h0000), rr};
    endfunction

    // Compare process: check the DUT against the model, then advance the model
    always @(negedge clk) begin
        bit   ev, eir;
        exp_t e;
        ev  = (q.size() > 0) && (q[0].rdy <= cyc);
        eir = !rst && ((q.size() == 0) || (ev && out_ready));
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'(eir));
            if (ev) begin
                chk("result", 32'(result), 32'(q[0].res));
                chk("flags", 32'(flags), 32'(q[0].flg));
                chk("out_tag", 32'(out_tag), 32'(q[0].tag));
            end
            if (rst_seen) begin
                chk("rst_result", 32'(result), 32'h0);
                chk("rst_flags", 32'(flags), 32'h0);
                chk("rst_tag", 32'(out_tag), 32'h0);
            end
        end
        if (rst) begin
            q.delete();
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (ev && out_ready) begin
                void'(q.pop_front());
            end
            if (in_valid && eir) begin
                {e.flg, e.res} = ref_alu(opcode, A, B);
                e.tag = in_tag;
                e.rdy = cyc + 1 + (op_is_mul(opcode) ? W : 0);
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] t);
        in_valid = v; opcode = op; A = a; B = b; in_tag = t;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t, input int idle);
        drive(1'b1, op, a, b, t);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < idle; i++) step();
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] corners [5];
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return 16'($urandom());
    endfunction

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0);

        // Pin the model itself with hand-computed values
        chk("pin_add", 32'(ref_alu(4'd0, 16'h7FFF, 16'h0001)), 32'({4'b1010, 16'h8000}));
        chk("pin_sub", 32'(ref_alu(4'd1, 16'h0003, 16'h0005)), 32'({4'b0110, 16'hFFFE}));
        chk("pin_sra", 32'(ref_alu(4'd8, 16'h8000, 16'h0004)), 32'({4'b0010, 16'hF800}));
        chk("pin_slt", 32'(ref_alu(4'd9, 16'hFFFF, 16'h0001)), 32'({4'b0000, 16'h0001}));
        chk("pin_shl", 32'(ref_alu(4'd5, 16'h8001, 16'h0011)), 32'({4'b0100, 16'h0002}));
`ifdef ALU_MUL_EN
        chk("pin_mul", 32'(ref_alu(4'd7, 16'h0100, 16'h0100)), 32'({4'b0101, 16'h0000}));
`else
        chk("pin_mul", 32'(ref_alu(4'd7, 16'h0100, 16'h0100)), 32'({4'b0001, 16'h0000}));
`endif

        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Directed ADD with literal expectations one edge after accept
        drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'd3);
        step();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'h1);
        chk("add_result", 32'(result), 32'h8000);
        chk("add_flags", 32'(flags), 32'hA);
        chk("add_tag", 32'(out_tag), 32'h3);
        step();

        issue(4'd1, 16'h0003, 16'h0005, 4'd1, 1);
        issue(4'd8, 16'h8000, 16'h0004, 4'd2, 1);
        issue(4'd9, 16'hFFFF, 16'h0001, 4'd4, 1);
        issue(4'd7, 16'h0100, 16'h0100, 4'd5, W + 3);

        // Four back-to-back ADDs
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd0, pick(), pick(), 4'(i + 1));
            step();
        end
        in_valid = 1'b0;
        step(); step();

        // Back-pressure: result held while issue stalls, then accepted on release
        issue(4'd0, 16'h1234, 16'h4321, 4'd6, 0);
        out_ready = 1'b0;
        drive(1'b1, 4'd4, 16'hF0F0, 16'h0FF0, 4'd7);
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();

        // Reset while an operation is in flight or held
        issue(4'd7, 16'h00FF, 16'h0101, 4'd8, 0);
        out_ready = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        issue(4'd0, 16'h0002, 16'h0003, 4'd9, 2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick(),
                  4'($urandom()));
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < W + 4; i++) step();
        chk("drained", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
